// File: rtl/axi4_wr_resp_tracker_pkg.sv
// Shared AXI write-response definitions: BRESP encodings and tracker FSM states.
package axi4_wr_resp_tracker_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } trk_state_e;

  function automatic logic is_err_resp(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_id_fifo.sv
// Synchronous ID FIFO holding the AWIDs of issued bursts in issue order.
module axi4_id_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: a word is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/axi4_wr_resp_tracker.sv
// AXI4 write-response tracker: counts issued bursts, owns B acceptance,
// checks ID order / BRESP / timeout and captures the first error.
module axi4_wr_resp_tracker
  import axi4_wr_resp_tracker_pkg::*;
#(
  parameter int IDSIZE          = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT         = 1024
) (
  input  logic                               axi_aclk,
  input  logic                               axi_aresetn,
  input  logic                               axi_awvalid,
  input  logic                               axi_awready,
  input  logic [IDSIZE-1:0]                  axi_awid,
  input  logic                               axi_bvalid,
  input  logic [IDSIZE-1:0]                  axi_bid,
  input  logic [1:0]                         axi_bresp,
  output logic                               axi_bready,
  output logic                               aw_allow,
  input  logic                               clear_err,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               idle,
  output logic                               burst_done,
  output logic                               resp_err,
  output logic                               id_err,
  output logic                               timeout_err,
  output logic [IDSIZE-1:0]                  err_id,
  output logic [1:0]                         err_resp
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  trk_state_e        state_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              idle_q, done_q;
  logic              resp_err_q, id_err_q, tmo_err_q;
  logic              resp_err_d, id_err_d, tmo_err_d, any_err_d;
  logic [IDSIZE-1:0] err_id_q, err_id_d, head;
  logic [1:0]        err_resp_q, err_resp_d;
  logic              empty, full, aw_fire, push, ovf, b_fire, id_mis, rsp_bad, tmo_evt, first;

  axi4_id_fifo #(.W(IDSIZE), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk    (axi_aclk),
    .rst_n  (axi_aresetn),
    .push_i (push),
    .pop_i  (b_fire),
    .din_i  (axi_awid),
    .head_o (head),
    .empty_o(empty),
    .full_o (full)
  );

  assign axi_bready = !empty;
  assign aw_allow   = (cnt_q < CW'(MAX_OUTSTANDING));
  assign aw_fire    = axi_awvalid && axi_awready;
  assign push       = aw_fire && !full;
  assign ovf        = aw_fire && full;
  assign b_fire     = axi_bvalid && !empty;
  assign id_mis     = b_fire && (axi_bid != head);
  assign rsp_bad    = b_fire && is_err_resp(axi_bresp);
  assign tmo_evt    = !b_fire && (cnt_q != '0) && (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d      = cnt_q + CW'(push) - CW'(b_fire);
    tmr_d      = tmr_q;
    if (b_fire || cnt_q == '0)       tmr_d = '0;
    else if (tmr_q != TW'(TIMEOUT))  tmr_d = tmr_q + TW'(1);
    // A new error in the clearing cycle survives the clear.
    resp_err_d = (resp_err_q && !clear_err) || rsp_bad;
    id_err_d   = (id_err_q   && !clear_err) || id_mis || ovf;
    tmo_err_d  = (tmo_err_q  && !clear_err) || tmo_evt;
    any_err_d  = resp_err_d || id_err_d || tmo_err_d;
    first      = clear_err || !(resp_err_q || id_err_q || tmo_err_q);
    err_id_d   = clear_err ? '0 : err_id_q;
    err_resp_d = clear_err ? '0 : err_resp_q;
    if (first) begin
      if (id_mis || rsp_bad) begin
        err_id_d   = axi_bid;
        err_resp_d = axi_bresp;
      end else if (ovf) begin
        err_id_d   = axi_awid;
        err_resp_d = RESP_OKAY;
      end else if (tmo_evt) begin
        err_id_d   = head;
        err_resp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= ST_IDLE;
      idle_q     <= 1'b1;
      cnt_q      <= '0;
      tmr_q      <= '0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
      id_err_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
      err_id_q   <= '0;
      err_resp_q <= '0;
    end else begin
      if (any_err_d)           state_q <= ST_ERROR;
      else if (cnt_d == '0)    state_q <= ST_IDLE;
      else                     state_q <= ST_ACTIVE;
      idle_q     <= !any_err_d && (cnt_d == '0);
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      done_q     <= b_fire && !is_err_resp(axi_bresp);
      resp_err_q <= resp_err_d;
      id_err_q   <= id_err_d;
      tmo_err_q  <= tmo_err_d;
      err_id_q   <= err_id_d;
      err_resp_q <= err_resp_d;
    end
  end

  assign outstanding = cnt_q;
  assign idle        = idle_q;
  assign burst_done  = done_q;
  assign resp_err    = resp_err_q;
  assign id_err      = id_err_q;
  assign timeout_err = tmo_err_q;
  assign err_id      = err_id_q;
  assign err_resp    = err_resp_q;

endmodule

// File: tb/tb_axi4_wr_resp_tracker.sv
// Directed bench for axi4_wr_resp_tracker with hand-computed expectations.
module tb_axi4_wr_resp_tracker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       awvalid, awready, bvalid, clr;
  logic [3:0] awid, bid, err_id;
  logic [1:0] bresp, err_resp;
  logic       bready, aw_allow, idle, burst_done, resp_err, id_err, timeout_err;
  logic [4:0] outstanding;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  axi4_wr_resp_tracker dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_awid   (awid),
    .axi_bvalid (bvalid),
    .axi_bid    (bid),
    .axi_bresp  (bresp),
    .axi_bready (bready),
    .aw_allow   (aw_allow),
    .clear_err  (clr),
    .outstanding(outstanding),
    .idle       (idle),
    .burst_done (burst_done),
    .resp_err   (resp_err),
    .id_err     (id_err),
    .timeout_err(timeout_err),
    .err_id     (err_id),
    .err_resp   (err_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [3:0] id);
    awvalid = 1'b1; awready = 1'b1; awid = id;
    cyc();
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic b(input logic [3:0] id, input logic [1:0] r);
    bvalid = 1'b1; bid = id; bresp = r;
    cyc();
    bvalid = 1'b0;
  endtask

  task automatic chk_flags0(input string tag);
    chk({tag, ".resp_err"}, resp_err, 0);
    chk({tag, ".id_err"}, id_err, 0);
    chk({tag, ".timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; awvalid = 1'b0; awready = 1'b0; awid = '0;
    bvalid = 1'b0; bid = '0; bresp = '0; clr = 1'b0;
    cyc(3);
    chk("rst.outstanding", outstanding, 0);
    chk("rst.bready", bready, 0);
    chk("rst.aw_allow", aw_allow, 1);
    chk("rst.idle", idle, 1);
    chk("rst.burst_done", burst_done, 0);
    chk("rst.err_id", err_id, 0);
    chk_flags0("rst");
    rst_n = 1'b1;
    cyc();

    // Basic in-order issue and response
    aw(4'd0); chk("seq.out1", outstanding, 1); chk("seq.idle1", idle, 0);
    aw(4'd1); chk("seq.out2", outstanding, 2);
    aw(4'd2); chk("seq.out3", outstanding, 3); chk("seq.bready", bready, 1);
    b(4'd0, 2'd0); chk("seq.out4", outstanding, 2); chk("seq.done1", burst_done, 1);
    cyc();        chk("seq.done_gap", burst_done, 0);
    b(4'd1, 2'd1); chk("seq.out5", outstanding, 1); chk("seq.done2", burst_done, 1);
    b(4'd2, 2'd0); chk("seq.out6", outstanding, 0); chk("seq.done3", burst_done, 1);
    chk("seq.idle_end", idle, 1); chk("seq.bready_end", bready, 0);
    chk_flags0("seq");

    // Fill to capacity, then overflow
    for (int i = 0; i < 16; i++) aw(4'(i));
    chk("full.out", outstanding, 16); chk("full.aw_allow", aw_allow, 0);
    chk("full.id_err_pre", id_err, 0);
    aw(4'd15);
    chk("ovf.id_err", id_err, 1); chk("ovf.out", outstanding, 16); chk("ovf.idle", idle, 0);
    for (int i = 0; i < 16; i++) b(4'(i), 2'd0);
    chk("drain.out", outstanding, 0); chk("drain.id_err_sticky", id_err, 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("drain.id_err_clr", id_err, 0); chk("drain.idle", idle, 1);

    // Wrong ID with SLVERR; first-error capture
    aw(4'd5); b(4'd6, 2'd2);
    chk("err.id_err", id_err, 1); chk("err.resp_err", resp_err, 1);
    chk("err.err_id", err_id, 6); chk("err.err_resp", err_resp, 2);
    chk("err.idle", idle, 0); chk("err.done", burst_done, 0);
    aw(4'd7); b(4'd8, 2'd3);
    chk("err2.err_id_kept", err_id, 6); chk("err2.err_resp_kept", err_resp, 2);
    aw(4'd1);
    clr = 1'b1; bvalid = 1'b1; bid = 4'd2; bresp = 2'd0;
    cyc();
    clr = 1'b0; bvalid = 1'b0;
    chk("clrerr.id_err_new", id_err, 1); chk("clrerr.resp_err_gone", resp_err, 0);
    chk("clrerr.err_id", err_id, 2); chk("clrerr.err_resp", err_resp, 0);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk_flags0("clr"); chk("clr.err_id", err_id, 0); chk("clr.idle", idle, 1);

    // Timeout
    aw(4'd9);
    cyc(1000); chk("tmo.early", timeout_err, 0);
    cyc(30);
    chk("tmo.flag", timeout_err, 1); chk("tmo.err_id", err_id, 9); chk("tmo.err_resp", err_resp, 0);
    chk("tmo.bready", bready, 1);
    b(4'd9, 2'd0);
    chk("tmo.after_b", timeout_err, 1); chk("tmo.done", burst_done, 1); chk("tmo.out", outstanding, 0);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("tmo.clr", timeout_err, 0);
    aw(4'd3); aw(4'd4);
    cyc(1000); b(4'd3, 2'd0); cyc(100);
    chk("tmo.b_resets_counter", timeout_err, 0);
    b(4'd4, 2'd0); chk("tmo.idle", idle, 1);

    // Simultaneous AW and B keep count and order
    aw(4'd1); aw(4'd2); aw(4'd3); aw(4'd4);
    chk("sim.out_pre", outstanding, 4);
    awvalid = 1'b1; awready = 1'b1; awid = 4'd5;
    bvalid = 1'b1; bid = 4'd1; bresp = 2'd0;
    cyc();
    awvalid = 1'b0; awready = 1'b0; bvalid = 1'b0;
    chk("sim.out", outstanding, 4); chk("sim.done", burst_done, 1); chk("sim.id_err", id_err, 0);
    b(4'd2, 2'd0); b(4'd3, 2'd0); b(4'd4, 2'd0); b(4'd5, 2'd0);
    chk("sim.order", id_err, 0); chk("sim.out_end", outstanding, 0); chk("sim.idle", idle, 1);

    // Reset with bursts open
    for (int i = 0; i < 7; i++) aw(4'(i));
    chk("mrst.out_pre", outstanding, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.out", outstanding, 0); chk("mrst.bready", bready, 0);
    chk("mrst.idle", idle, 1); chk("mrst.aw_allow", aw_allow, 1);
    chk_flags0("mrst");
    cyc(); rst_n = 1'b1; cyc(2);
    chk("mrst.idle_after", idle, 1); chk_flags0("mrst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
